multi_phase_accumulator: RTL and testbench

//  Time-multiplexed DDS phase accumulator for NUM_CH tone channels sharing one adder.
//  - Each sample period (master_count_in == 0) starts one sweep: every channel is updated, one per clock.
//  - Emits a stream of (channel, phase, valid) to the downstream waveform/mixer stage.
//  - Successor to the single-channel accumulator; adds channels, parametrised phase width and phase-reset control.

---
 rtl/multi_phase_accumulator.sv | 168 ++++++++++++++++
 tb/tb_multi_phase_accumulator.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_phase_accumulator.sv
// Time-multiplexed DDS phase accumulator: NUM_CH channels share one adder, one channel per clock.
// Optional `define PHASE_RESET_EN adds a per-channel pending phase-reset mask at address 4'hF.
//
// state    | meaning
// ST_IDLE  | waiting for master_count_in == 0 (re-armed by a nonzero count seen here)
// ST_SWEEP | updating channel ch_q this cycle, last channel returns to ST_IDLE
module multi_phase_accumulator #(
    parameter int NUM_CH  = 4,
    parameter int PHASE_W = 16,
    parameter int CNT_W   = 10,
    parameter int CH_W    = 3
) (
    input  logic               clk_in,
    input  logic               reset_n_in,
    input  logic [CNT_W-1:0]   master_count_in,
    input  logic [15:0]        data_in,
    input  logic [3:0]         addr_in,
    input  logic               data_valid_in,
    output logic [PHASE_W-1:0] data_out,
    output logic [CH_W-1:0]    ch_out,
    output logic               data_valid_out,
    output logic               busy_out
);

    typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic               arm_q, arm_d;
    logic [PHASE_W-1:0] phase_q [NUM_CH];
    logic [PHASE_W-1:0] phase_d [NUM_CH];
    logic [PHASE_W-1:0] incr_q  [NUM_CH];
    logic [PHASE_W-1:0] incr_d  [NUM_CH];
    logic [PHASE_W-1:0] data_q, data_d;
    logic [CH_W-1:0]    ch_out_q, ch_out_d;
    logic               valid_q, valid_d;

    logic [PHASE_W-1:0] sel_phase, sel_incr, sum;
    logic               last_ch, trigger;

`ifdef PHASE_RESET_EN
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic               sel_mask;
`endif

    assign trigger = (master_count_in == '0);
    assign last_ch = (ch_q == CH_W'(NUM_CH - 1));
    assign sum     = sel_phase + sel_incr;

    // Mux the active channel by compare so CH_W may exceed the index width.
    always_comb begin
        sel_phase = '0;
        sel_incr  = '0;
`ifdef PHASE_RESET_EN
        sel_mask  = 1'b0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
                sel_phase = phase_q[i];
                sel_incr  = incr_q[i];
`ifdef PHASE_RESET_EN
                sel_mask  = mask_q[i];
`endif
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        arm_d    = arm_q;
        phase_d  = phase_q;
        incr_d   = incr_q;
        data_d   = data_q;
        ch_out_d = ch_out_q;
        valid_d  = 1'b0;
`ifdef PHASE_RESET_EN
        mask_d   = mask_q;
`endif

        for (int i = 0; i < NUM_CH; i++) begin
            if (data_valid_in && addr_in == 4'(i)) begin
                incr_d[i] = PHASE_W'(data_in);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (trigger && arm_q) begin
                    state_d = ST_SWEEP;
                    ch_d    = '0;
                    arm_d   = 1'b0;
                end else if (!trigger) begin
                    arm_d   = 1'b1;
                end
            end
            ST_SWEEP: begin
                valid_d  = 1'b1;
                ch_out_d = ch_q;
                data_d   = sum;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_q == CH_W'(i)) begin
                        phase_d[i] = sum;
`ifdef PHASE_RESET_EN
                        if (sel_mask) begin
                            phase_d[i] = '0;
                            mask_d[i]  = 1'b0;
                        end
`endif
                    end
                end
`ifdef PHASE_RESET_EN
                if (sel_mask) data_d = '0;
`endif
                if (last_ch) begin
                    state_d = ST_IDLE;
                    ch_d    = '0;
                end else begin
                    ch_d    = ch_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef PHASE_RESET_EN
        // Applied after the clear so a bit set during its own channel's update survives to next sweep.
        if (data_valid_in && addr_in == 4'hF) begin
            mask_d = mask_d | data_in[NUM_CH-1:0];
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            arm_q    <= 1'b1;
            data_q   <= '0;
            ch_out_q <= '0;
            valid_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                phase_q[i] <= '0;
                incr_q[i]  <= '0;
            end
`ifdef PHASE_RESET_EN
            mask_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            arm_q    <= arm_d;
            data_q   <= data_d;
            ch_out_q <= ch_out_d;
            valid_q  <= valid_d;
            phase_q  <= phase_d;
            incr_q   <= incr_d;
`ifdef PHASE_RESET_EN
            mask_q   <= mask_d;
`endif
        end
    end

    assign data_out       = data_q;
    assign ch_out         = ch_out_q;
    assign data_valid_out = valid_q;
    assign busy_out       = (state_q == ST_SWEEP);

endmodule

// File: tb/tb_multi_phase_accumulator.sv
// Directed bench for multi_phase_accumulator (NUM_CH=4, PHASE_W=16).
module tb_multi_phase_accumulator;

    logic        clk_in = 1'b0;
    logic        reset_n_in;
    logic [9:0]  master_count_in;
    logic [15:0] data_in;
    logic [3:0]  addr_in;
    logic        data_valid_in;
    logic [15:0] data_out;
    logic [2:0]  ch_out;
    logic        data_valid_out;
    logic        busy_out;

    int n_checks = 0;
    int n_fails  = 0;

    multi_phase_accumulator #(
        .NUM_CH(4), .PHASE_W(16), .CNT_W(10), .CH_W(3)
    ) dut (
        .clk_in          (clk_in),
        .reset_n_in      (reset_n_in),
        .master_count_in (master_count_in),
        .data_in         (data_in),
        .addr_in         (addr_in),
        .data_valid_in   (data_valid_in),
        .data_out        (data_out),
        .ch_out          (ch_out),
        .data_valid_out  (data_valid_out),
        .busy_out        (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset_n_in = 1'b0;
        tick();
        tick();
        reset_n_in = 1'b1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        addr_in       = a;
        data_in       = d;
        data_valid_in = 1'b1;
        tick();
        data_valid_in = 1'b0;
    endtask

    task automatic set_incr(input logic [15:0] i0, i1, i2, i3);
        wr(4'd0, i0);
        wr(4'd1, i1);
        wr(4'd2, i2);
        wr(4'd3, i3);
    endtask

    task automatic run_sweep(input string tag, input logic [15:0] e0, e1, e2, e3);
        logic [15:0] exp_d [4];
        exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2; exp_d[3] = e3;
        master_count_in = 10'd0;
        tick();
        master_count_in = 10'd7;
        chk({tag, " busy_at_T"}, 32'(busy_out), 32'd1);
        chk({tag, " valid_at_T"}, 32'(data_valid_out), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("%s valid%0d", tag, k), 32'(data_valid_out), 32'd1);
            chk($sformatf("%s ch%0d", tag, k), 32'(ch_out), 32'(k));
            chk($sformatf("%s data%0d", tag, k), 32'(data_out), 32'(exp_d[k]));
            chk($sformatf("%s busy%0d", tag, k), 32'(busy_out), (k < 3) ? 32'd1 : 32'd0);
        end
        tick();
        chk({tag, " valid_after"}, 32'(data_valid_out), 32'd0);
        chk({tag, " data_hold"}, 32'(data_out), 32'(e3));
        chk({tag, " ch_hold"}, 32'(ch_out), 32'd3);
    endtask

    initial begin
        int n_valid;
        int n_busy;
        master_count_in = 10'd5;
        data_in         = 16'h0;
        addr_in         = 4'h0;
        data_valid_in   = 1'b0;

        // Reset and idle behaviour
        do_reset();
        tick();
        chk("rst data", 32'(data_out), 32'd0);
        chk("rst ch", 32'(ch_out), 32'd0);
        chk("rst valid", 32'(data_valid_out), 32'd0);
        chk("rst busy", 32'(busy_out), 32'd0);
        for (int i = 0; i < 3; i++) begin
            master_count_in = 10'(i + 1);
            tick();
            chk("idle valid", 32'(data_valid_out), 32'd0);
        end

        // Basic accumulation
        set_incr(16'd1, 16'd2, 16'd3, 16'd4);
        run_sweep("s1", 16'd1, 16'd2, 16'd3, 16'd4);
        run_sweep("s2", 16'd2, 16'd4, 16'd6, 16'd8);

        // Increment written while its channel updates: old incr now, new incr next sweep
        master_count_in = 10'd0;
        tick();
        master_count_in = 10'd7;
        tick();
        chk("wcol ch0", 32'(data_out), 32'd3);
        addr_in = 4'd1; data_in = 16'd10; data_valid_in = 1'b1;
        tick();
        data_valid_in = 1'b0;
        chk("wcol ch1 ch", 32'(ch_out), 32'd1);
        chk("wcol ch1 old incr", 32'(data_out), 32'd6);
        tick();
        tick();
        tick();
        run_sweep("wcol next", 16'd4, 16'd16, 16'd12, 16'd16);

        // Wrap-around, incr = 0 channels hold and still report valid
        do_reset();
        wr(4'd0, 16'hC000);
        run_sweep("wrap1", 16'hC000, 16'd0, 16'd0, 16'd0);
        run_sweep("wrap2", 16'h8000, 16'd0, 16'd0, 16'd0);
        run_sweep("wrap3", 16'h4000, 16'd0, 16'd0, 16'd0);

        // Out-of-map address ignored
        wr(4'd7, 16'h1234);
        run_sweep("badaddr", 16'h0000, 16'd0, 16'd0, 16'd0);

        // Trigger held low for 6 cycles gives one sweep only
        do_reset();
        set_incr(16'd1, 16'd2, 16'd3, 16'd4);
        n_valid = 0;
        n_busy  = 0;
        master_count_in = 10'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_valid += int'(data_valid_out);
            n_busy  += int'(busy_out);
        end
        master_count_in = 10'd9;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_valid += int'(data_valid_out);
            n_busy  += int'(busy_out);
        end
        chk("hold0 valid pulses", 32'(n_valid), 32'd4);
        chk("hold0 busy cycles", 32'(n_busy), 32'd4);
        run_sweep("hold0 next", 16'd2, 16'd4, 16'd6, 16'd8);

        // Phase-reset mask
        do_reset();
        set_incr(16'd1, 16'd2, 16'd3, 16'd4);
        run_sweep("pr0", 16'd1, 16'd2, 16'd3, 16'd4);
        wr(4'hF, 16'h0002);
`ifdef PHASE_RESET_EN
        run_sweep("pr1", 16'd2, 16'd0, 16'd6, 16'd8);
        run_sweep("pr2", 16'd3, 16'd2, 16'd9, 16'd12);
`else
        run_sweep("pr1", 16'd2, 16'd4, 16'd6, 16'd8);
        run_sweep("pr2", 16'd3, 16'd6, 16'd9, 16'd12);
`endif

        // Reset mid-sweep at ch2
        do_reset();
        set_incr(16'd1, 16'd2, 16'd3, 16'd4);
        run_sweep("ab0", 16'd1, 16'd2, 16'd3, 16'd4);
        master_count_in = 10'd0;
        tick();
        master_count_in = 10'd7;
        tick();
        tick();
        chk("ab pre ch", 32'(ch_out), 32'd1);
        reset_n_in = 1'b0;
        tick();
        chk("ab valid", 32'(data_valid_out), 32'd0);
        chk("ab busy", 32'(busy_out), 32'd0);
        chk("ab data", 32'(data_out), 32'd0);
        chk("ab ch", 32'(ch_out), 32'd0);
        reset_n_in = 1'b1;
        tick();
        set_incr(16'd1, 16'd2, 16'd3, 16'd4);
        run_sweep("ab restart", 16'd1, 16'd2, 16'd3, 16'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
